// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_bus_arbiter : shares one SRAM-like bridge port between icache and dcache
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module cache_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WIDTH    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic                 c_OWN_DATA = 1'b0;
   localparam logic                 c_OWN_INST = 1'b1;
   localparam logic [CNT_WIDTH-1:0] c_LIMIT    = CNT_WIDTH'(STARVE_LIMIT);

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_owner;
   logic                 w_owner_next;
   logic [CNT_WIDTH-1:0] r_starve_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_next;
   logic                 w_grant_inst;
   logic                 w_sel_inst;
   logic                 w_acc;

   // Inst wins only when forced by starvation or when data is not asking.
   assign w_grant_inst = inst_req & ((r_starve_cnt == c_LIMIT) | ~data_req);
   assign w_sel_inst   = (r_state == S_IDLE) ? w_grant_inst : r_owner;

   assign bus_wr    = w_sel_inst ? inst_wr    : data_wr;
   assign bus_size  = w_sel_inst ? inst_size  : data_size;
   assign bus_addr  = w_sel_inst ? inst_addr  : data_addr;
   assign bus_wdata = w_sel_inst ? inst_wdata : data_wdata;

   assign w_acc        = bus_req & bus_addr_ok;
   assign inst_addr_ok = w_acc &  w_sel_inst;
   assign data_addr_ok = w_acc & ~w_sel_inst;

   assign inst_data_ok = (r_state == S_RESP) & (r_owner == c_OWN_INST) & bus_data_ok;
   assign data_data_ok = (r_state == S_RESP) & (r_owner == c_OWN_DATA) & bus_data_ok;
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_cnt_next   = r_starve_cnt;
      bus_req      = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus_req = inst_req | data_req;
            if (bus_req) begin
               w_owner_next = w_grant_inst;
               w_state_next = bus_addr_ok ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            if (bus_addr_ok) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (bus_data_ok) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // Starvation counts consecutive data acceptances while inst is waiting.
      if (w_acc) begin
         if (!w_sel_inst && inst_req) begin
            w_cnt_next = (r_starve_cnt == c_LIMIT) ? c_LIMIT : r_starve_cnt + 1'b1;
         end else begin
            w_cnt_next = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= c_OWN_DATA;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_starve_cnt <= w_cnt_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cache_bus_arbiter : directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter.
// ----------------------------------------------------------------------------
module tb_cache_bus_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_addr_ok, bus_data_ok;

   int n_checks = 0;
   int n_errors = 0;

   // Model: owner waiting for address acceptance, owner waiting for data (-1 = none)
   int m_lock, m_wait, m_cnt;
   logic e_bus_req, e_iaok, e_daok, e_idok, e_ddok;
   int   e_sel;

   always #5 clk = ~clk;

   cache_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Settle, derive expected outputs from the model, compare every output.
   task automatic check();
      logic acc;
      #1;
      e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0; e_sel = 0;
      if (m_wait >= 0) begin
         e_bus_req = 1'b0;
         e_idok = (m_wait == 1) && bus_data_ok;
         e_ddok = (m_wait == 0) && bus_data_ok;
      end else if (m_lock >= 0) begin
         e_bus_req = 1'b1;
         e_sel = m_lock;
      end else begin
         e_bus_req = inst_req | data_req;
         e_sel = (inst_req && (m_cnt >= LIMIT || !data_req)) ? 1 : 0;
      end
      acc = e_bus_req && bus_addr_ok;
      e_iaok = acc && (e_sel == 1);
      e_daok = acc && (e_sel == 0);
      chk("bus_req", {31'd0, bus_req}, {31'd0, e_bus_req});
      if (e_bus_req) begin
         chk("bus_addr",  bus_addr,  e_sel ? inst_addr  : data_addr);
         chk("bus_wdata", bus_wdata, e_sel ? inst_wdata : data_wdata);
         chk("bus_wr",    {31'd0, bus_wr}, {31'd0, e_sel ? inst_wr : data_wr});
         chk("bus_size",  {30'd0, bus_size}, {30'd0, e_sel ? inst_size : data_size});
      end
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_iaok});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_daok});
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_idok});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_ddok});
      if (e_idok) chk("inst_rdata", inst_rdata, bus_rdata);
      if (e_ddok) chk("data_rdata", data_rdata, bus_rdata);
   endtask

   // Apply the clock edge to the model, then advance the DUT one cycle.
   task automatic tick();
      if (rst) begin
         m_lock = -1; m_wait = -1; m_cnt = 0;
      end else if (m_wait >= 0) begin
         if (bus_data_ok) m_wait = -1;
      end else if (e_bus_req) begin
         if (bus_addr_ok) begin
            m_wait = e_sel;
            m_lock = -1;
            if (e_sel == 1)    m_cnt = 0;
            else if (inst_req) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
            else               m_cnt = 0;
         end else begin
            m_lock = e_sel;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      check();
      tick();
   endtask

   task automatic quiet();
      inst_req = 0; data_req = 0; inst_wr = 0; data_wr = 0;
      inst_size = 2'b10; data_size = 2'b10;
      inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   initial begin
      quiet();
      rst = 1;
      m_lock = -1; m_wait = -1; m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // Reset state: nothing requested, nothing acked.
      check();
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      tick();

      // Instruction fetch, same-cycle accept, data three cycles later.
      inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1;
      check();
      chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
      chk("t1_bus_addr", bus_addr, 32'hBFC00000);
      tick();
      inst_req = 0; bus_addr_ok = 0;
      cyc(); cyc();
      bus_data_ok = 1; bus_rdata = 32'h24080001;
      check();
      chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
      chk("t1_inst_rdata", inst_rdata, 32'h24080001);
      chk("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
      tick();
      bus_data_ok = 0;

      // Simultaneous requests: data first, inst in the IDLE cycle after data_data_ok.
      do_reset();
      inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; bus_addr_ok = 1;
      check();
      chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      chk("t2_bus_addr", bus_addr, 32'h2000);
      tick();
      data_req = 0; bus_data_ok = 1;
      cyc();
      bus_data_ok = 0;
      check();
      chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
      tick();
      inst_req = 0; bus_data_ok = 1;
      cyc();
      bus_data_ok = 0;

      // Starvation: four data grants, then inst, then counter back to zero.
      do_reset();
      inst_req = 1; inst_addr = 32'h3000; data_req = 1; data_addr = 32'h4000;
      for (int k = 0; k < 6; k++) begin
         bus_addr_ok = 1; bus_data_ok = 0;
         check();
         if (k == 4) chk("t3_inst_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
         else        chk("t3_data_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
         tick();
         bus_addr_ok = 0; bus_data_ok = 1;
         cyc();
      end
      quiet();
      cyc();

      // Locked owner: inst stalls two cycles while data rises.
      do_reset();
      inst_req = 1; inst_addr = 32'h5000;
      check();
      tick();
      data_req = 1; data_addr = 32'h6000;
      check();
      chk("t4_bus_addr_locked", bus_addr, 32'h5000);
      chk("t4_no_data_ack", {31'd0, data_addr_ok}, 32'd0);
      tick();
      bus_addr_ok = 1;
      check();
      chk("t4_inst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
      tick();
      inst_req = 0; bus_addr_ok = 0;
      check();
      chk("t4_data_wait", {31'd0, data_addr_ok}, 32'd0);
      tick();
      bus_data_ok = 1;
      cyc();
      bus_data_ok = 0; data_req = 0;
      cyc();

      // Data write passes through unmodified.
      do_reset();
      data_req = 1; data_wr = 1; data_size = 2'b10;
      data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF; bus_addr_ok = 1;
      check();
      chk("t5_bus_wr", {31'd0, bus_wr}, 32'd1);
      chk("t5_bus_addr", bus_addr, 32'h80001000);
      chk("t5_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("t5_bus_size", {30'd0, bus_size}, 32'd2);
      tick();
      data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
      check();
      chk("t5_data_data_ok", {31'd0, data_data_ok}, 32'd1);
      tick();
      bus_data_ok = 0;

      // Reset while a response is outstanding; the late data_ok is dropped.
      do_reset();
      data_req = 1; data_addr = 32'h7000; bus_addr_ok = 1;
      cyc();
      data_req = 0; bus_addr_ok = 0; rst = 1;
      cyc();
      rst = 0; bus_data_ok = 1;
      check();
      chk("t6_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      tick();
      bus_data_ok = 0; inst_req = 1; data_req = 1; bus_addr_ok = 1;
      check();
      chk("t6_cnt_cleared", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
      tick();
      quiet();
      bus_data_ok = 1;
      cyc();

      // Random traffic.
      quiet();
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!inst_req && $urandom_range(0, 3) == 0) begin
            inst_req = 1; inst_wr = $urandom_range(0, 1); inst_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom; inst_wdata = $urandom;
         end
         if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req = 1; data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
            data_addr = $urandom; data_wdata = $urandom;
         end
         bus_addr_ok = ($urandom_range(0, 2) == 0);
         bus_data_ok = (m_wait >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bus_rdata = $urandom;
         check();
         tick();
         if (e_iaok) inst_req = 0;
         if (e_daok) data_req = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
